// File: rtl/apb_uart_tx_sched_if.sv
// APB bus between the TX scheduler (master) and the UART register slave.
interface apb_uart_tx_sched_if #(
    parameter int APB_ADDR_WIDTH = 12
) ();
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic [31:0]               pwdata;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [31:0]               prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_uart_tx_sched.sv
// APB master owning the UART register port: programs the UART after reset,
// then feeds bytes from N_REQ producers round-robin into THR, keeping a local
// TX FIFO credit that is refilled only when LSR reports an empty transmitter.
module apb_uart_tx_sched #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          N_REQ          = 4,
    parameter logic [15:0] DIVISOR        = 16'h0064,
    parameter logic [7:0]  LCR_CFG        = 8'h03,
    parameter int          TX_FIFO_DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 init_done_o,
    output logic                 err_o,
    apb_uart_tx_sched_if.master  apb
);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CW-1:0] CREDIT_FULL = CW'(TX_FIFO_DEPTH);

    typedef enum logic [3:0] {
        INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR,
        IDLE, GRANT, WRITE, POLL
    } state_t;

    state_t        state;
    logic [CW-1:0] credit;
    logic [PW-1:0] rr_ptr;
    logic [7:0]    tx_byte;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [2:0]    reg_q;
    logic [7:0]    wdata_q;

    logic             pick_found;
    logic [N_REQ-1:0] pick_onehot;
    logic [7:0]       pick_data;
    logic [PW-1:0]    pick_next;
    int               pick_dist;

    logic xfer_done;
    logic unused_prdata;

    assign apb.paddr   = APB_ADDR_WIDTH'(reg_q);
    assign apb.pwdata  = {24'h0, wdata_q};
    assign apb.pwrite  = pwrite_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;

    assign xfer_done     = psel_q & penable_q & apb.pready;
    assign unused_prdata = ^{apb.prdata[31:6], apb.prdata[4:0]};

    // Register index and data of each init write, packed as {reg, byte}.
    function automatic logic [10:0] init_xfer(state_t s);
        case (s)
            INIT_DLAB: init_xfer = {3'd3, LCR_CFG | 8'h80};
            INIT_DLL:  init_xfer = {3'd0, DIVISOR[7:0]};
            INIT_DLM:  init_xfer = {3'd1, DIVISOR[15:8]};
            INIT_LCR:  init_xfer = {3'd3, LCR_CFG & 8'h7F};
            default:   init_xfer = {3'd2, 8'h06};
        endcase
    endfunction

    function automatic state_t next_init(state_t s);
        case (s)
            INIT_DLAB: next_init = INIT_DLL;
            INIT_DLL:  next_init = INIT_DLM;
            INIT_DLM:  next_init = INIT_LCR;
            default:   next_init = INIT_FCR;
        endcase
    endfunction

    // Round-robin pick: valid requester with the smallest distance from rr_ptr.
    always_comb begin
        pick_dist   = N_REQ;
        pick_onehot = '0;
        pick_data   = 8'h00;
        pick_next   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid_i[i] && (((i + N_REQ - int'(rr_ptr)) % N_REQ) < pick_dist)) begin
                pick_dist      = (i + N_REQ - int'(rr_ptr)) % N_REQ;
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_data      = req_data_i[8*i +: 8];
                pick_next      = PW'((i + 1) % N_REQ);
            end
        end
        pick_found = |pick_onehot;
    end

    // Scheduler FSM with APB phase sequencing; init writes run back to back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= INIT_DLAB;
            credit      <= '0;
            rr_ptr      <= '0;
            tx_byte     <= 8'h00;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            reg_q       <= 3'd0;
            wdata_q     <= 8'h00;
            req_ready_o <= '0;
            init_done_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            req_ready_o <= '0;
            if (psel_q && !penable_q) begin
                penable_q <= 1'b1;
            end
            if (xfer_done && apb.pslverr) begin
                err_o <= 1'b1;
            end
            case (state)
                INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR: begin
                    if (!psel_q) begin
                        psel_q           <= 1'b1;
                        penable_q        <= 1'b0;
                        pwrite_q         <= 1'b1;
                        {reg_q, wdata_q} <= init_xfer(state);
                    end else if (xfer_done) begin
                        if (state == INIT_FCR) begin
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            init_done_o <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            penable_q        <= 1'b0;
                            {reg_q, wdata_q} <= init_xfer(next_init(state));
                            state            <= next_init(state);
                        end
                    end
                end
                IDLE: begin
                    if (|req_valid_i) begin
                        state <= (credit == '0) ? POLL : GRANT;
                    end
                end
                GRANT: begin
                    if (pick_found) begin
                        req_ready_o <= pick_onehot;
                        tx_byte     <= pick_data;
                        rr_ptr      <= pick_next;
                        state       <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (!psel_q) begin
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b1;
                        reg_q     <= 3'd0;
                        wdata_q   <= tx_byte;
                    end else if (xfer_done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (credit != '0) begin
                            credit <= credit - 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                POLL: begin
                    if (!psel_q) begin
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        reg_q     <= 3'd5;
                        wdata_q   <= 8'h00;
                    end else if (xfer_done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (apb.prdata[5]) begin
                            credit <= CREDIT_FULL;
                            state  <= (|req_valid_i) ? GRANT : IDLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart_tx_sched.sv
// Bench for apb_uart_tx_sched: UART APB slave model, byte producers, and a
// transaction-level reference model of init, round-robin and LSR credit rules.
module tb_apb_uart_tx_sched;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            init_done;
    logic            err;

    apb_uart_tx_sched_if #(.APB_ADDR_WIDTH(12)) apb ();

    apb_uart_tx_sched #(
        .APB_ADDR_WIDTH(12), .N_REQ(NR), .DIVISOR(16'h0064),
        .LCR_CFG(8'h03), .TX_FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rstn(rstn), .req_valid_i(req_valid), .req_data_i(req_data),
        .req_ready_o(req_ready), .init_done_o(init_done), .err_o(err), .apb(apb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [7:0]  data;
        int          dur;
        int          waits;
    } txn_t;

    int   asserts = 0;
    int   failures = 0;
    txn_t obs_q[$];
    txn_t exp_q[$];
    int   obs_gidx[$], obs_gpos[$], exp_gidx[$], exp_gpos[$];

    logic [7:0] prod_mem [NR][32];
    int         prod_len [NR];
    int         prod_rd  [NR];
    logic [7:0] lsr_q[$];
    logic [7:0] lsr_m[$];

    int          wait_thr = 0;
    bit          rand_wait = 0;
    bit          err_en = 0;
    bit          err_model = 0;
    int          m_credit = 0;
    int          m_ptr = 0;
    int          cyc = 0;
    int          cnt = 0;
    int          cur_wait = 0;
    int          dur = 0;
    bit          done_seen = 0;
    int          done_cycle = -1;
    logic [11:0] snap_addr;
    logic [31:0] snap_wdata;
    logic        snap_wr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refreshReq(input int i);
        req_valid[i] = (prod_rd[i] < prod_len[i]);
        req_data[8*i +: 8] = req_valid[i] ? prod_mem[i][prod_rd[i]] : 8'h00;
    endtask

    function automatic txn_t mk(input logic wr, input int addr, input int data);
        txn_t t;
        t.wr = wr;
        t.addr = 12'(addr);
        t.data = 8'(data);
        t.dur = 0;
        t.waits = (wr && addr == 0) ? wait_thr : 0;
        return t;
    endfunction

    // Cycle counter since reset release, used for init latency.
    always @(posedge clk) begin
        if (!rstn) cyc = 0;
        else cyc = cyc + 1;
    end

    // UART slave model plus bus/grant monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rstn) begin
            apb.pready = 1'b0;
            apb.pslverr = 1'b0;
            cnt = 0;
        end else begin
            if (apb.psel && !apb.penable) begin
                snap_addr = apb.paddr;
                snap_wdata = apb.pwdata;
                snap_wr = apb.pwrite;
                dur = 1;
                if (rand_wait) cur_wait = int'($urandom_range(0, 2));
                else cur_wait = (apb.pwrite && apb.paddr == 12'd0) ? wait_thr : 0;
                cnt = cur_wait;
                apb.pready = 1'b0;
                apb.pslverr = 1'b0;
                apb.prdata = {24'h0, (lsr_q.size() > 0) ? lsr_q[0] : 8'h60};
            end else if (apb.psel && apb.penable) begin
                txn_t t;
                dur++;
                checkOutput("hold_paddr", 32'(apb.paddr), 32'(snap_addr));
                checkOutput("hold_pwdata", apb.pwdata, snap_wdata);
                checkOutput("hold_pwrite", 32'(apb.pwrite), 32'(snap_wr));
                if (cnt == 0) begin
                    apb.pready = 1'b1;
                    apb.pslverr = err_en && ($urandom_range(0, 3) == 0);
                    if (apb.pslverr) err_model = 1'b1;
                    t.wr = snap_wr;
                    t.addr = snap_addr;
                    t.data = snap_wdata[7:0];
                    t.dur = dur;
                    t.waits = cur_wait;
                    obs_q.push_back(t);
                    if (!snap_wr && lsr_q.size() > 0) void'(lsr_q.pop_front());
                end else begin
                    cnt--;
                    apb.pready = 1'b0;
                    apb.pslverr = 1'b0;
                end
            end else begin
                apb.pready = 1'b0;
                apb.pslverr = 1'b0;
            end
            if (init_done && !done_seen) begin
                done_seen = 1'b1;
                done_cycle = cyc;
            end
            if (req_ready != '0) begin
                int gi;
                gi = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) gi = i;
                checkOutput("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                checkOutput("ready_after_init", 32'(init_done), 32'd1);
                obs_gidx.push_back(gi);
                obs_gpos.push_back(obs_q.size());
                prod_rd[gi]++;
                refreshReq(gi);
            end
        end
    end

    // Reference model: init writes, then LSR polls whenever credit is zero and
    // round-robin THR writes while any producer still holds bytes.
    task automatic buildExpected(input bit with_init);
        int rd[NR];
        int total;
        logic [7:0] r;
        exp_q.delete();
        exp_gidx.delete();
        exp_gpos.delete();
        if (with_init) begin
            exp_q.push_back(mk(1, 3, 8'h83));
            exp_q.push_back(mk(1, 0, 8'h64));
            exp_q.push_back(mk(1, 1, 8'h00));
            exp_q.push_back(mk(1, 3, 8'h03));
            exp_q.push_back(mk(1, 2, 8'h06));
        end
        total = 0;
        for (int i = 0; i < NR; i++) begin
            rd[i] = 0;
            total += prod_len[i];
        end
        while (total > 0) begin
            if (m_credit == 0) begin
                r = (lsr_m.size() > 0) ? lsr_m.pop_front() : 8'h60;
                exp_q.push_back(mk(0, 5, 0));
                if (r[5]) m_credit = 16;
            end else begin
                int w;
                w = -1;
                for (int k = 0; k < NR; k++)
                    if (w < 0 && rd[(m_ptr + k) % NR] < prod_len[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
                exp_gidx.push_back(w);
                exp_gpos.push_back(exp_q.size());
                exp_q.push_back(mk(1, 0, int'(prod_mem[w][rd[w]])));
                rd[w]++;
                total--;
                m_ptr = (w + 1) % NR;
                m_credit--;
            end
        end
    endtask

    task automatic applyStimulus(input bit do_reset);
        @(negedge clk);
        req_valid = '0;
        if (do_reset) begin
            rstn = 1'b0;
            repeat (2) @(negedge clk);
            checkOutput("rst_psel", 32'(apb.psel), 0);
            checkOutput("rst_penable", 32'(apb.penable), 0);
            checkOutput("rst_paddr", 32'(apb.paddr), 0);
            checkOutput("rst_ready", 32'(req_ready), 0);
            checkOutput("rst_init_done", 32'(init_done), 0);
            checkOutput("rst_err", 32'(err), 0);
            m_credit = 0;
            m_ptr = 0;
            err_model = 1'b0;
            done_seen = 1'b0;
            done_cycle = -1;
        end
        obs_q.delete();
        obs_gidx.delete();
        obs_gpos.delete();
        buildExpected(do_reset);
        for (int i = 0; i < NR; i++) begin
            prod_rd[i] = 0;
            refreshReq(i);
        end
        if (do_reset) rstn = 1'b1;
    endtask

    task automatic compareRun(input bit do_reset);
        int budget;
        int n;
        budget = 4000;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("txn_timeout", 32'(budget > 0), 1);
        repeat (30) @(negedge clk);
        checkOutput("txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("txn_wr", 32'(obs_q[i].wr), 32'(exp_q[i].wr));
            checkOutput("txn_addr", 32'(obs_q[i].addr), 32'(exp_q[i].addr));
            checkOutput("txn_data", 32'(obs_q[i].data), 32'(exp_q[i].data));
            checkOutput("txn_dur", 32'(obs_q[i].dur),
                        32'(2 + (rand_wait ? obs_q[i].waits : exp_q[i].waits)));
        end
        checkOutput("grant_count", 32'(obs_gidx.size()), 32'(exp_gidx.size()));
        n = (obs_gidx.size() < exp_gidx.size()) ? obs_gidx.size() : exp_gidx.size();
        for (int i = 0; i < n; i++) begin
            checkOutput("grant_idx", 32'(obs_gidx[i]), 32'(exp_gidx[i]));
            checkOutput("grant_pos", 32'(obs_gpos[i]), 32'(exp_gpos[i]));
        end
        checkOutput("err_sticky", 32'(err), 32'(err_model));
        if (do_reset && !rand_wait && wait_thr == 0)
            checkOutput("init_done_cycle", 32'(done_cycle), 32'd11);
    endtask

    task automatic clearProducers();
        for (int i = 0; i < NR; i++) prod_len[i] = 0;
        lsr_q.delete();
        lsr_m.delete();
    endtask

    task automatic addLsr(input logic [7:0] v);
        lsr_q.push_back(v);
        lsr_m.push_back(v);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit found;
        int budget;
        apb.prdata = '0;
        apb.pready = 1'b0;
        apb.pslverr = 1'b0;
        for (int i = 0; i < NR; i++) begin
            prod_len[i] = 0;
            prod_rd[i] = 0;
        end

        $display("[TB] single request after init");
        clearProducers();
        prod_len[2] = 1;
        prod_mem[2][0] = 8'h41;
        addLsr(8'h60);
        applyStimulus(1);
        compareRun(1);

        $display("[TB] all requesters valid, credit exhaustion");
        clearProducers();
        for (int i = 0; i < NR; i++) begin
            prod_len[i] = 5;
            for (int j = 0; j < 5; j++) prod_mem[i][j] = 8'($urandom);
        end
        applyStimulus(1);
        compareRun(1);

        $display("[TB] LSR not empty three times");
        clearProducers();
        prod_len[0] = 1;
        prod_mem[0][0] = 8'h33;
        addLsr(8'h00);
        addLsr(8'h00);
        addLsr(8'h00);
        addLsr(8'h20);
        applyStimulus(1);
        compareRun(1);

        $display("[TB] pready wait states on THR write");
        clearProducers();
        wait_thr = 5;
        prod_len[3] = 1;
        prod_mem[3][0] = 8'hC5;
        applyStimulus(0);
        compareRun(0);
        wait_thr = 0;

        $display("[TB] randomized rounds");
        rand_wait = 1;
        err_en = 1;
        for (int r = 0; r < 6; r++) begin
            clearProducers();
            for (int i = 0; i < NR; i++) begin
                prod_len[i] = int'($urandom_range(0, 6));
                for (int j = 0; j < prod_len[i]; j++) prod_mem[i][j] = 8'($urandom);
            end
            for (int k = int'($urandom_range(0, 3)); k > 0; k--) addLsr(8'($urandom));
            applyStimulus(r % 3 == 0);
            compareRun(r % 3 == 0);
        end
        rand_wait = 0;
        err_en = 0;

        $display("[TB] reset during THR write");
        clearProducers();
        wait_thr = 40;
        prod_len[1] = 1;
        prod_mem[1][0] = 8'h5A;
        applyStimulus(1);
        found = 1'b0;
        budget = 400;
        while (!found && budget > 0) begin
            @(negedge clk);
            budget--;
            if (apb.psel && apb.penable && apb.pwrite && apb.paddr == 12'd0 && done_seen) found = 1'b1;
        end
        checkOutput("thr_access_seen", 32'(found), 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_rst_psel", 32'(apb.psel), 0);
        checkOutput("async_rst_penable", 32'(apb.penable), 0);
        wait_thr = 0;
        clearProducers();
        applyStimulus(1);
        compareRun(1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
